// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : counter_pkg                                                     |
// | Purpose  : End-of-range mode constants and one-shot state encoding shared  |
// |            by the up/down counter family.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package counter_pkg;

    localparam int CNT_MODE_WRAP    = 0;
    localparam int CNT_MODE_SAT     = 1;
    localparam int CNT_MODE_ONESHOT = 2;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } oneshot_state_e;

endpackage
`default_nettype wire

// File: rtl/updown_counter_mod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : updown_counter_mod                                              |
// | Purpose  : Modulo-MODULO up/down counter with clear, load, terminal count  |
// |            and wrap / saturate / one-shot end-of-range behaviour.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULO    = 16,
    parameter int MODE      = 0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] c_max         = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] c_rst         = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);
    localparam logic [WIDTH:0]   c_modulo      = (WIDTH+1)'(MODULO);
    localparam logic             c_hold_at_end = (MODE != CNT_MODE_WRAP);
    localparam logic             c_oneshot     = (MODE == CNT_MODE_ONESHOT);

    generate
        if (WIDTH < 1 || MODULO < 2 || 64'(MODULO) > (64'd1 << WIDTH) ||
            RESET_VAL < 0 || RESET_VAL >= MODULO ||
            MODE < CNT_MODE_WRAP || MODE > CNT_MODE_ONESHOT) begin : g_param_check
            $error("updown_counter_mod: illegal WIDTH/MODULO/MODE/RESET_VAL combination");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_load_err;
    oneshot_state_e   r_state;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;
    logic             w_load_err_nxt;
    logic             w_arrive;
    oneshot_state_e   w_state_nxt;

    always_comb begin
        w_count_nxt    = r_count;
        w_wrap_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
        w_arrive       = 1'b0;
        w_state_nxt    = r_state;

        if (clear) begin
            w_count_nxt = c_rst;
            w_state_nxt = ST_RUN;
        end else if (load) begin
            w_state_nxt = ST_RUN;
            if ({1'b0, load_val} < c_modulo) begin
                w_count_nxt = load_val;
            end else begin
                w_count_nxt    = c_max;
                w_load_err_nxt = 1'b1;
            end
        end else if (en && (r_state == ST_RUN)) begin
            // Explicit end compares keep non-power-of-two ranges exact.
            if (up_dn) begin
                if (r_count != c_max) begin
                    w_count_nxt = r_count + c_one;
                    w_arrive    = (r_count == c_max - c_one);
                end else if (!c_hold_at_end) begin
                    w_count_nxt = '0;
                    w_wrap_nxt  = 1'b1;
                end
            end else begin
                if (r_count != '0) begin
                    w_count_nxt = r_count - c_one;
                    w_arrive    = (r_count == c_one);
                end else if (!c_hold_at_end) begin
                    w_count_nxt = c_max;
                    w_wrap_nxt  = 1'b1;
                end
            end

            // Saturating modes pulse only on the step that lands on the end.
            if (w_arrive && c_hold_at_end) begin
                w_wrap_nxt = 1'b1;
                if (c_oneshot) begin
                    w_state_nxt = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count    <= c_rst;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            r_state    <= ST_RUN;
        end else begin
            r_count    <= w_count_nxt;
            r_wrap     <= w_wrap_nxt;
            r_load_err <= w_load_err_nxt;
            r_state    <= w_state_nxt;
        end
    end

    assign count    = r_count;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;
    assign done     = c_oneshot && (r_state == ST_DONE);
    assign tc       = en & ((up_dn & (r_count == c_max)) | (~up_dn & (r_count == '0)));

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_mod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_updown_counter_mod                                           |
// | Purpose  : Self-checking bench for updown_counter_mod in all three modes.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_updown_counter_mod;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       reset_n, clear, load, en, up_dn;
    logic [3:0] load_val;

    logic [3:0] cnt  [NI];
    logic       tc_o [NI];
    logic       wr   [NI];
    logic       dn   [NI];
    logic       le   [NI];

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(4), .MODULO(10), .MODE(0), .RESET_VAL(0)) u0 (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .count(cnt[0]), .tc(tc_o[0]),
        .wrap(wr[0]), .done(dn[0]), .load_err(le[0]));

    updown_counter_mod #(.WIDTH(4), .MODULO(10), .MODE(1), .RESET_VAL(0)) u1 (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .count(cnt[1]), .tc(tc_o[1]),
        .wrap(wr[1]), .done(dn[1]), .load_err(le[1]));

    updown_counter_mod #(.WIDTH(4), .MODULO(10), .MODE(2), .RESET_VAL(0)) u2 (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .count(cnt[2]), .tc(tc_o[2]),
        .wrap(wr[2]), .done(dn[2]), .load_err(le[2]));

    updown_counter_mod #(.WIDTH(4), .MODULO(16), .MODE(0), .RESET_VAL(5)) u3 (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .count(cnt[3]), .tc(tc_o[3]),
        .wrap(wr[3]), .done(dn[3]), .load_err(le[3]));

    // Reference model state: plain integers, one entry per instance.
    int pm    [NI];
    int pmode [NI];
    int prv   [NI];
    int m_c   [NI];
    bit m_w   [NI];
    bit m_d   [NI];
    bit m_e   [NI];
    bit tc_valid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit rn, clr, ld, en, ud;
        int lv;
        int exp_c;
        bit exp_w;
        bit exp_e;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rn, bit clr, bit ld, bit e, bit ud, int lv,
                                int c, bit w, bit er);
        vec_t v;
        v.rn = rn; v.clr = clr; v.ld = ld; v.en = e; v.ud = ud; v.lv = lv;
        v.exp_c = c; v.exp_w = w; v.exp_e = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit rn, input bit clr, input bit ld, input bit e,
                         input bit ud, input int lv);
        reset_n  = rn;
        clear    = clr;
        load     = ld;
        en       = e;
        up_dn    = ud;
        load_val = 4'(lv);
    endtask

    task automatic model_update();
        for (int i = 0; i < NI; i++) begin
            int c, m, endv, nxt;
            c = m_c[i];
            m = pm[i];
            m_w[i] = 1'b0;
            m_e[i] = 1'b0;
            if (!reset_n || clear) begin
                m_c[i] = prv[i];
                m_d[i] = 1'b0;
            end else if (load) begin
                m_d[i] = 1'b0;
                if (int'(load_val) < m) m_c[i] = int'(load_val);
                else begin
                    m_c[i] = m - 1;
                    m_e[i] = 1'b1;
                end
            end else if (en && !m_d[i]) begin
                endv = up_dn ? m - 1 : 0;
                if (pmode[i] == 0) begin
                    nxt = up_dn ? (c + 1) % m : (c + m - 1) % m;
                    m_w[i] = (c == endv);
                end else begin
                    nxt = (c == endv) ? c : (up_dn ? c + 1 : c - 1);
                    m_w[i] = (nxt == endv) && (c != endv);
                    if (pmode[i] == 2 && m_w[i]) m_d[i] = 1'b1;
                end
                m_c[i] = nxt;
            end
        end
    endtask

    // Apply current inputs for one clock, checking tc before and registers after.
    task automatic cycle();
        #2;
        if (tc_valid) begin
            for (int i = 0; i < NI; i++) begin
                bit exp_tc;
                exp_tc = en && ((up_dn && m_c[i] == pm[i] - 1) || (!up_dn && m_c[i] == 0));
                chk($sformatf("u%0d.tc", i), 32'(tc_o[i]), 32'(exp_tc));
            end
        end
        @(posedge clk);
        model_update();
        #1;
        tc_valid = 1'b1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d.count", i),    32'(cnt[i]), 32'(m_c[i]));
            chk($sformatf("u%0d.wrap", i),     32'(wr[i]),  32'(m_w[i]));
            chk($sformatf("u%0d.done", i),     32'(dn[i]),  32'(m_d[i]));
            chk($sformatf("u%0d.load_err", i), 32'(le[i]),  32'(m_e[i]));
        end
    endtask

    initial begin
        bit ud_r;
        pm    = '{10, 10, 10, 16};
        pmode = '{0, 1, 2, 0};
        prv   = '{0, 0, 0, 5};
        for (int i = 0; i < NI; i++) begin
            m_c[i] = prv[i]; m_w[i] = 0; m_d[i] = 0; m_e[i] = 0;
        end
        drive(0, 0, 0, 0, 0, 0);

        // Directed table; expectations below are for the MODULO=10 wrap instance.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,  0, 0, 0));
        for (int k = 1; k <= 12; k++)
            vecs.push_back(mk(1, 0, 0, 1, 1, 0, k % 10, k == 10, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,  1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,  9, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,  8, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,  7, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 5,  0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 12, 9, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  9, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 6,  6, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0,  1, 0, 0));

        foreach (vecs[k]) begin
            drive(vecs[k].rn, vecs[k].clr, vecs[k].ld, vecs[k].en, vecs[k].ud, vecs[k].lv);
            cycle();
            chk($sformatf("tbl[%0d].count", k),    32'(cnt[0]), 32'(vecs[k].exp_c));
            chk($sformatf("tbl[%0d].wrap", k),     32'(wr[0]),  32'(vecs[k].exp_w));
            chk($sformatf("tbl[%0d].load_err", k), 32'(le[0]),  32'(vecs[k].exp_e));
        end

        // Saturate and one-shot arrival at the top end.
        drive(1, 0, 1, 0, 1, 8);
        cycle();
        chk("sat.load8", 32'(cnt[1]), 32'd8);
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 1, 1, 0);
            cycle();
            chk("sat.hold9",  32'(cnt[1]), 32'd9);
            chk("sat.wrap1x", 32'(wr[1]),  32'(k == 0));
            chk("os.wrap1x",  32'(wr[2]),  32'(k == 0));
            chk("os.done",    32'(dn[2]),  32'd1);
        end
        drive(1, 0, 0, 1, 0, 0);
        cycle();
        chk("sat.down8",    32'(cnt[1]), 32'd8);
        chk("os.reverse9",  32'(cnt[2]), 32'd9);

        // One-shot: clear, run to the end, stay done, reload to restart.
        drive(1, 1, 0, 0, 1, 0);
        cycle();
        chk("os.clear.cnt",  32'(cnt[2]), 32'd0);
        chk("os.clear.done", 32'(dn[2]),  32'd0);
        for (int k = 1; k <= 14; k++) begin
            drive(1, 0, 0, 1, 1, 0);
            cycle();
            chk("os.run.cnt",  32'(cnt[2]), 32'((k < 9) ? k : 9));
            chk("os.run.done", 32'(dn[2]),  32'(k >= 9));
        end
        drive(1, 0, 1, 1, 1, 3);
        cycle();
        chk("os.load3.cnt",  32'(cnt[2]), 32'd3);
        chk("os.load3.done", 32'(dn[2]),  32'd0);
        drive(1, 0, 0, 1, 1, 0);
        cycle();
        chk("os.resume", 32'(cnt[2]), 32'd4);

        // Randomised traffic against the model.
        ud_r = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) ud_r = ~ud_r;
            drive($urandom_range(0, 59) != 0,
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 14) == 0,
                  $urandom_range(0, 3) != 0,
                  ud_r,
                  int'($urandom_range(0, 15)));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parameterised successor to the team's 4-bit free-running up counter. Counts up or down modulo MODULO, with enable, synchronous clear and parallel load. Three end-of-range modes: wrap, saturate, one-shot. Used as the general-purpose event, timer and index counter in later designs. Provides a terminal-count flag and a registered wrap/done indication for downstream sequencing.

Parameters:
WIDTH, 4, bit width of count; MODULO <= 2**WIDTH required.
MODULO, 16, count range 0..MODULO-1; must be >= 2.
MODE, 0, 0 = wrap, 1 = saturate, 2 = one-shot.
RESET_VAL, 0, count value after reset and clear; must be < MODULO.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  synchronous, active-low reset.
en  input  1  count enable; one step per clk when high.
up_dn  input  1  1 = count up, 0 = count down; sampled only when en=1.
clear  input  1  synchronous clear to RESET_VAL.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  value loaded when load=1.
count  output  WIDTH  current count (registered).
tc  output  1  combinational terminal count: en & ((up_dn & count==MODULO-1) | (~up_dn & count==0)).
wrap  output  1  registered 1-cycle pulse, asserted the cycle after count crosses the range end (MODE 0) or first hits the end (MODE 1/2).
done  output  1  MODE 2 only: sticky, set on reaching terminal; always 0 in MODE 0/1.
load_err  output  1  registered 1-cycle pulse when load_val >= MODULO.

Behaviour:
- Reset, synchronous at a clk edge with reset_n=0: count=RESET_VAL, wrap=0, done=0, load_err=0.
- Priority per edge: reset_n low > clear > load > en. Lower-priority inputs are ignored that cycle.
- clear: count=RESET_VAL; done=0; wrap=0.
- load: count=load_val if load_val < MODULO, else count=MODULO-1 and load_err=1 next cycle. load also clears done. The loaded value is visible the cycle after the edge.
- en=0 with no clear/load: count holds; wrap=0.
- Up-step (en=1, up_dn=1):
  - count < MODULO-1: count+1.
  - At MODULO-1, MODE 0: count=0, wrap=1.
  - At MODULO-1, MODE 1: count holds; wrap=1 only on the step that first reached MODULO-1, so wrap pulses once per arrival at the end, not every held cycle.
- Down-step: symmetric, with 0 as the end and MODULO-1 as the wrap target.
- Saturate-pulse rule: wrap pulses on the edge where count transitions into the end value with en=1 in the same direction. Internally, a 1-bit state records the arrival.
- MODE 2 (one-shot) FSM, states RUN and DONE:
  - RUN counts as MODE 1.
  - On the edge where count becomes the end value: enter DONE, done=1, wrap=1 for one cycle.
  - In DONE, en is ignored and count holds.
  - clear or load returns to RUN.
  - Reversing up_dn while in DONE does not restart counting.
- Arithmetic is modulo MODULO, not 2**WIDTH. Non-power-of-two MODULO uses explicit compare, never natural overflow.
- Reset mid-count, or reset coincident with load/clear/en: reset wins and all outputs take reset values next cycle.
- tc is combinational and may be used in the same cycle to chain counters (cascade en of the next stage = tc).

Decomposition:
- Shared package counter_pkg: mode constants (CNT_MODE_WRAP=0, CNT_MODE_SAT=1, CNT_MODE_ONESHOT=2) and the one-shot state encoding (ST_RUN, ST_DONE).
- Parameter legality checked by an elaboration-time assertion/generate error.
- No sub-module needed. The next-count logic stays in a single combinational block inside the module.

Test Plan:
- MODE 0, WIDTH=4, MODULO=10: reset_n=0 for 2 clk, then en=1, up_dn=1 for 12 clk -> count 0..9,0,1. wrap=1 exactly in the cycle after 9->0; tc=1 while count=9.
- MODE 0, MODULO=10: en=1, up_dn=0 from count=0 -> count 9,8,7. wrap pulses once after 0->9.
- MODE 1, MODULO=10: load 8, count up 4 clk -> 9,9,9,9. wrap pulses once; then up_dn=0 -> 8.
- MODE 2, MODULO=10: clear, count up to 9 -> done=1 and stays 1 with en=1 for 5 more clk, count=9. load=1, load_val=3 -> count=3, done=0, counting resumes.
- Priority: load=1 (load_val=5), clear=1, en=1 on the same edge -> count=RESET_VAL. load=1 with load_val=12 (MODULO=10) -> count=9, load_err pulses 1 cycle.
- Reset mid-operation: count=6 with en=1, assert reset_n=0 for 1 clk -> count=0, wrap=0, done=0 the next cycle. Counting resumes after reset_n=1.
